// File: rtl/uart_register_bridge_if.sv
// Register-bus side of the UART debug bridge: request/grant plus read/write strobes.
// Signals: bus_request_o/bus_grant_i arbitration, register_index_o (12b), register_read_o/register_write_o strobes,
//          register_write_value_o (16b) toward peripherals, register_read_value_i (16b, valid the cycle after a read strobe).
// master = bridge (initiator), slave = bus mux / register file side.
interface uart_register_bridge_if;
    logic        bus_request_o;
    logic        bus_grant_i;
    logic [11:0] register_index_o;
    logic        register_read_o;
    logic        register_write_o;
    logic [15:0] register_write_value_o;
    logic [15:0] register_read_value_i;

    modport master (
        output bus_request_o, register_index_o, register_read_o, register_write_o, register_write_value_o,
        input  bus_grant_i, register_read_value_i
    );

    modport slave (
        input  bus_request_o, register_index_o, register_read_o, register_write_o, register_write_value_o,
        output bus_grant_i, register_read_value_i
    );
endinterface

// File: rtl/uart_register_bridge.sv
// Purpose: 8N1 UART command stream (W: 57 IH IL VH VL, R: 52 IH IL) -> register bus transaction, answered over UART TX.
// Latency: request one cycle after the last stop-bit sample; strobe the cycle after grant; response starts the cycle after RESP entry.
// Backpressure: waits indefinitely for bus_grant_i; bytes arriving while a transaction is in flight are dropped.
// Ports: clk, reset (async active-low), uart_rx_i, uart_tx_o, bus (uart_register_bridge_if.master).
// Optional: define BRIDGE_TIMEOUT_EN to abandon a half-received command after TIMEOUT_CYCLES without a new start bit.
module uart_register_bridge #(
    parameter int CLKS_PER_BIT   = 217
`ifdef BRIDGE_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 250000
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx_i,
    output logic                          uart_tx_o,
    uart_register_bridge_if.master        bus
);
    localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]      OP_WRITE  = 8'h57;
    localparam logic [7:0]      OP_READ   = 8'h52;

    // ---------------- RX ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t      r_rx_state;
    logic           r_rx_meta, r_rx_sync, r_rx_prev;
    logic [CW-1:0]  r_rx_cnt;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic           r_rx_vld, r_rx_ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_vld   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) r_rx_state <= RX_START;
                end
                RX_START: begin
                    // Re-check mid start bit so a glitch does not start a frame.
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_vld   <= r_rx_sync;
                        r_rx_ferr  <= !r_rx_sync;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- response queue + TX serializer ----------------
    // Up to three pending bytes live in r_q_sr, oldest in [23:16].
    logic [23:0]    r_q_sr;
    logic [1:0]     r_q_cnt;
    logic           r_tx_busy, r_tx_line;
    logic [8:0]     r_tx_frame;
    logic [3:0]     r_tx_bit;
    logic [CW-1:0]  r_tx_cnt;
    logic           w_tx_last, w_tx_load;
    logic [23:0]    w_q_sr;
    logic [1:0]     w_q_cnt;

    // Loading on the final stop-bit cycle gives back-to-back frames.
    assign w_tx_last = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == BIT_LAST);
    assign w_tx_load = (r_q_cnt != 2'd0) && (!r_tx_busy || w_tx_last);

    always_comb begin
        w_q_sr  = r_q_sr;
        w_q_cnt = r_q_cnt;
        if (w_tx_load) begin
            w_q_sr  = {r_q_sr[15:0], 8'h00};
            w_q_cnt = r_q_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_busy  <= 1'b0;
            r_tx_line  <= 1'b1;
            r_tx_frame <= '0;
            r_tx_bit   <= '0;
            r_tx_cnt   <= '0;
        end else if (w_tx_load) begin
            r_tx_frame <= {1'b1, r_q_sr[23:16]};
            r_tx_line  <= 1'b0;
            r_tx_bit   <= '0;
            r_tx_cnt   <= '0;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == BIT_LAST) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx_line <= 1'b1;
                end else begin
                    r_tx_line  <= r_tx_frame[0];
                    r_tx_frame <= {1'b0, r_tx_frame[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
        end
    end

    assign uart_tx_o = r_tx_line;

    // ---------------- optional inter-byte timeout ----------------
    typedef enum logic [3:0] {
        IDLE, GET_IDX_HI, GET_IDX_LO, GET_VAL_HI, GET_VAL_LO, REQ, STROBE, CAPTURE, RESP
    } state_t;
    state_t r_state;
    logic   w_in_get;
    logic   w_timeout;

    assign w_in_get = (r_state == GET_IDX_HI) || (r_state == GET_IDX_LO) ||
                      (r_state == GET_VAL_HI) || (r_state == GET_VAL_LO);

`ifdef BRIDGE_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;

    // Any frame activity (start bit onward) restarts the idle count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                           r_to_cnt <= '0;
        else if (!w_in_get || r_rx_state != RX_IDLE || r_rx_vld) r_to_cnt <= '0;
        else if (r_to_cnt != TO_LAST)                          r_to_cnt <= r_to_cnt + TW'(1);
    end
    assign w_timeout = w_in_get && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------- command parser ----------------
    logic        r_is_write, r_req, r_rd, r_wr;
    logic [11:0] r_index;
    logic [15:0] r_wval;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_req      <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_index    <= '0;
            r_wval     <= '0;
            r_q_sr     <= '0;
            r_q_cnt    <= '0;
        end else begin
            r_q_sr  <= w_q_sr;
            r_q_cnt <= w_q_cnt;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            if (w_in_get && (r_rx_ferr || w_timeout)) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (r_rx_vld) begin
                        if (r_rx_shift == OP_WRITE || r_rx_shift == OP_READ) begin
                            r_is_write <= (r_rx_shift == OP_WRITE);
                            r_state    <= GET_IDX_HI;
                        end else if (w_q_cnt != 2'd3) begin
                            // Unknown opcode: queue '?' behind anything still pending.
                            case (w_q_cnt)
                                2'd0:    r_q_sr[23:16] <= 8'h3F;
                                2'd1:    r_q_sr[15:8]  <= 8'h3F;
                                default: r_q_sr[7:0]   <= 8'h3F;
                            endcase
                            r_q_cnt <= w_q_cnt + 2'd1;
                        end
                    end
                    GET_IDX_HI: if (r_rx_vld) begin
                        r_index[11:8] <= r_rx_shift[3:0];
                        r_state       <= GET_IDX_LO;
                    end
                    GET_IDX_LO: if (r_rx_vld) begin
                        r_index[7:0] <= r_rx_shift;
                        if (r_is_write) begin
                            r_state <= GET_VAL_HI;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                        end
                    end
                    GET_VAL_HI: if (r_rx_vld) begin
                        r_wval[15:8] <= r_rx_shift;
                        r_state      <= GET_VAL_LO;
                    end
                    GET_VAL_LO: if (r_rx_vld) begin
                        r_wval[7:0] <= r_rx_shift;
                        r_state     <= REQ;
                        r_req       <= 1'b1;
                    end
                    REQ: if (bus.bus_grant_i) begin
                        r_state <= STROBE;
                        r_wr    <= r_is_write;
                        r_rd    <= !r_is_write;
                    end
                    STROBE: begin
                        r_req <= 1'b0;
                        if (r_is_write) begin
                            r_q_sr  <= {8'h4B, 16'h0000};
                            r_q_cnt <= 2'd1;
                            r_state <= RESP;
                        end else begin
                            r_state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        r_q_sr  <= {8'h44, bus.register_read_value_i};
                        r_q_cnt <= 2'd3;
                        r_state <= RESP;
                    end
                    RESP: if (r_q_cnt == 2'd0 && !r_tx_busy) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.bus_request_o          = r_req;
    assign bus.register_read_o        = r_rd;
    assign bus.register_write_o       = r_wr;
    assign bus.register_index_o       = r_index;
    assign bus.register_write_value_o = r_wval;
endmodule
